// File: rtl/cpu_pkg.sv
// Shared datapath definitions for the CPU memory tiers.
// The word type and the RAM8 address width are used by every memory level.
package cpu_pkg;

    localparam int WORD_W  = 16;
    localparam int RAM8_AW = 3;

    typedef logic [WORD_W-1:0] word_t;

endpackage : cpu_pkg

// File: rtl/ram8_register16.sv
// 16-bit storage register with load enable and asynchronous active-low clear.
// One instance holds one word of the RAM8 tier.
module register16
    import cpu_pkg::*;
#(
    parameter int W = WORD_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    input  logic         load,
    output logic [W-1:0] q
);

    logic [W-1:0] word_reg;

    // Capture d on a loaded edge; clear takes priority and acts without the clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_reg <= '0;
        end else if (load) begin
            word_reg <= d;
        end
    end

    assign q = word_reg;

endmodule : register16

// File: rtl/ram8.sv
// Eight-word register-file memory: first tier of the CPU data memory.
// Writes are synchronous (one addressed word per edge); reads are combinational
// with no bypass, so out shows the old word until the write edge has passed.
module ram8
    import cpu_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = 8,
    parameter int AW    = RAM8_AW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic [AW-1:0]    address,
    output logic [WIDTH-1:0] out
);

    logic [DEPTH-1:0] load_sel;
    logic [WIDTH-1:0] word_q [DEPTH];

    // Each word gets its own register; load is demuxed so only the addressed word sees it.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            assign load_sel[gi] = load && (address == AW'(gi));

            register16 #(
                .W(WIDTH)
            ) u_word (
                .clk  (clk),
                .rst_n(rst_n),
                .d    (in),
                .load (load_sel[gi]),
                .q    (word_q[gi])
            );
        end
    endgenerate

    // Output mux: the addressed word, with no clock in the path.
    always_comb begin
        out = word_q[address];
    end

endmodule : ram8

// File: tb/tb_ram8.sv
// Directed bench for ram8: reset, write/read, isolation, read timing,
// asynchronous reset mid-run and boundary data values.
`timescale 1ns/1ps
module tb_ram8;

    logic        clk;
    logic        rst_n;
    logic [15:0] in;
    logic        load;
    logic [2:0]  address;
    logic [15:0] out;

    int errors;
    int checks;

    ram8 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in     (in),
        .load   (load),
        .address(address),
        .out    (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one word at a falling edge, let one rising edge write it, drop load.
    task automatic write_word(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        address = a;
        in      = d;
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        load    = 1'b0;
        in      = 16'h0000;
        address = 3'd0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            address = 3'(k);
            #1;
            checks++;
            if (out !== 16'h0000) begin
                errors++;
                $display("FAIL reset_held addr=%0d got=%h want=0000", k, out);
            end else
                $display("ok   reset_held addr=%0d out=%h", k, out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            address = 3'(k);
            #1;
            checks++;
            if (out !== 16'h0000) begin
                errors++;
                $display("FAIL reset_released addr=%0d got=%h want=0000", k, out);
            end else
                $display("ok   reset_released addr=%0d out=%h", k, out);
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        address = 3'd2;
        in      = 16'h1234;
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
        in      = 16'h0000;
        @(negedge clk);
        address = 3'd2;
        #1;
        checks++;
        if (out !== 16'h1234) begin
            errors++;
            $display("FAIL write_read addr=2 got=%h want=1234", out);
        end else
            $display("ok   write_read addr=2 out=%h", out);
    endtask

    task automatic test_isolation();
        logic [15:0] exp;
        for (int k = 0; k < 8; k++)
            write_word(3'(k), 16'h1000 + 16'(k));
        for (int k = 0; k < 8; k++) begin
            address = 3'(k);
            #1;
            exp = 16'h1000 + 16'(k);
            checks++;
            if (out !== exp) begin
                errors++;
                $display("FAIL isolation_fill addr=%0d got=%h want=%h", k, out, exp);
            end else
                $display("ok   isolation_fill addr=%0d out=%h", k, out);
        end
        write_word(3'd5, 16'hBEEF);
        for (int k = 0; k < 8; k++) begin
            address = 3'(k);
            #1;
            exp = (k == 5) ? 16'hBEEF : 16'h1000 + 16'(k);
            checks++;
            if (out !== exp) begin
                errors++;
                $display("FAIL isolation_rewrite addr=%0d got=%h want=%h", k, out, exp);
            end else
                $display("ok   isolation_rewrite addr=%0d out=%h", k, out);
        end
    endtask

    task automatic test_read_timing();
        write_word(3'd3, 16'h0003);
        @(negedge clk);
        address = 3'd3;
        in      = 16'hAAAA;
        load    = 1'b1;
        #1;
        checks++;
        if (out !== 16'h0003) begin
            errors++;
            $display("FAIL timing_before_edge got=%h want=0003", out);
        end else
            $display("ok   timing_before_edge out=%h", out);
        @(posedge clk);
        #1;
        checks++;
        if (out !== 16'hAAAA) begin
            errors++;
            $display("FAIL timing_after_edge got=%h want=aaaa", out);
        end else
            $display("ok   timing_after_edge out=%h", out);
        @(negedge clk);
        load    = 1'b0;
        address = 3'd5;
        #1;
        checks++;
        if (out !== 16'hBEEF) begin
            errors++;
            $display("FAIL timing_comb_addr5 got=%h want=beef", out);
        end else
            $display("ok   timing_comb_addr5 out=%h", out);
        address = 3'd1;
        #1;
        checks++;
        if (out !== 16'h1001) begin
            errors++;
            $display("FAIL timing_comb_addr1 got=%h want=1001", out);
        end else
            $display("ok   timing_comb_addr1 out=%h", out);
    endtask

    task automatic test_async_reset();
        // Words currently hold 1000+k except 3=AAAA and 5=BEEF.
        @(negedge clk);
        address = 3'd6;
        #1;
        checks++;
        if (out !== 16'h1006) begin
            errors++;
            $display("FAIL async_prefill got=%h want=1006", out);
        end else
            $display("ok   async_prefill out=%h", out);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out !== 16'h0000) begin
            errors++;
            $display("FAIL async_immediate addr=6 got=%h want=0000", out);
        end else
            $display("ok   async_immediate addr=6 out=%h", out);
        for (int k = 0; k < 8; k++) begin
            address = 3'(k);
            #1;
            checks++;
            if (out !== 16'h0000) begin
                errors++;
                $display("FAIL async_cleared addr=%0d got=%h want=0000", k, out);
            end else
                $display("ok   async_cleared addr=%0d out=%h", k, out);
        end
        @(negedge clk);
        address = 3'd4;
        in      = 16'h5555;
        load    = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out !== 16'h0000) begin
            errors++;
            $display("FAIL async_load_blocked got=%h want=0000", out);
        end else
            $display("ok   async_load_blocked out=%h", out);
        @(negedge clk);
        load  = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (out !== 16'h0000) begin
            errors++;
            $display("FAIL async_after_release got=%h want=0000", out);
        end else
            $display("ok   async_after_release out=%h", out);
    endtask

    task automatic test_boundary();
        write_word(3'd7, 16'hFFFF);
        write_word(3'd0, 16'h0000);
        write_word(3'd1, 16'h8001);
        address = 3'd7;
        #1;
        checks++;
        if (out !== 16'hFFFF) begin
            errors++;
            $display("FAIL boundary_addr7 got=%h want=ffff", out);
        end else
            $display("ok   boundary_addr7 out=%h", out);
        address = 3'd0;
        #1;
        checks++;
        if (out !== 16'h0000) begin
            errors++;
            $display("FAIL boundary_addr0 got=%h want=0000", out);
        end else
            $display("ok   boundary_addr0 out=%h", out);
        address = 3'd1;
        #1;
        checks++;
        if (out !== 16'h8001) begin
            errors++;
            $display("FAIL boundary_addr1 got=%h want=8001", out);
        end else
            $display("ok   boundary_addr1 out=%h", out);
    endtask

    task automatic test_back_to_back();
        // Two consecutive loaded edges on one address: the second value stays.
        @(negedge clk);
        address = 3'd6;
        in      = 16'h1111;
        load    = 1'b1;
        @(negedge clk);
        in      = 16'h2222;
        @(negedge clk);
        load    = 1'b0;
        #1;
        checks++;
        if (out !== 16'h2222) begin
            errors++;
            $display("FAIL back_to_back got=%h want=2222", out);
        end else
            $display("ok   back_to_back out=%h", out);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_write_read();
        test_isolation();
        test_read_timing();
        test_async_reset();
        test_boundary();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ram8
